calc_occ: RTL

Occ-lookup and interval-update stage placed directly downstream of the ROM-fetch stage (`get_data_1`). It accepts one request per handshake, carrying the search parameters (i, z, k, l), the fetched C value and the current position code. When the request needs an Occ lookup, it reads Occ(b, k-1) and Occ(b, l) from the single-port synchronous `rom_Occ`. It then produces the updated SA interval k' = C + Occ(b, k-1) + 1 and l' = C + Occ(b, l) for the next stage.

---
 rtl/calc_occ.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/calc_occ.sv
// Occ lookup and SA-interval update stage: reads Occ(b,k-1) and Occ(b,l) from a
// single-port synchronous ROM and produces k' = C + Occ(b,k-1) + 1, l' = C + Occ(b,l).
module calc_occ (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        need_occ,
    input  logic [7:0]  i_in,
    input  logic [7:0]  z_in,
    input  logic [7:0]  k_in,
    input  logic [7:0]  l_in,
    input  logic [11:0] addr_in,
    input  logic [4:0]  position_in,
    input  logic [7:0]  d_i_in,
    input  logic [1:0]  read_i_in,
    input  logic [7:0]  C_in,
    output logic        busy,
    output logic        ce_rom_Occ,
    output logic [9:0]  addr_rom_Occ,
    input  logic [7:0]  occ_data,
    output logic        out_valid,
    output logic [7:0]  i_out,
    output logic [7:0]  z_out,
    output logic [7:0]  k_out,
    output logic [7:0]  l_out,
    output logic [11:0] addr_out,
    output logic [4:0]  position_out,
    output logic [7:0]  d_i_out,
    output logic [1:0]  read_i_out,
    output logic [7:0]  k_new,
    output logic [7:0]  l_new,
    output logic        interval_empty
);

    localparam logic [4:0] A_MATCH        = 5'd0;
    localparam logic [4:0] A_MISMATCH     = 5'd1;
    localparam logic [4:0] A_INSERTION    = 5'd2;
    localparam logic [4:0] A_DELETION     = 5'd3;
    localparam logic [4:0] C_MATCH        = 5'd4;
    localparam logic [4:0] C_MISMATCH     = 5'd5;
    localparam logic [4:0] C_INSERTION    = 5'd6;
    localparam logic [4:0] C_DELETION     = 5'd7;
    localparam logic [4:0] G_MATCH        = 5'd8;
    localparam logic [4:0] G_MISMATCH     = 5'd9;
    localparam logic [4:0] G_INSERTION    = 5'd10;
    localparam logic [4:0] G_DELETION     = 5'd11;
    localparam logic [4:0] T_MATCH        = 5'd12;
    localparam logic [4:0] T_MISMATCH     = 5'd13;
    localparam logic [4:0] T_INSERTION    = 5'd14;
    localparam logic [4:0] T_DELETION     = 5'd15;
    localparam logic [4:0] NONE           = 5'd16;
    localparam logic [4:0] STOP_MATCH     = 5'd17;
    localparam logic [4:0] STOP_MISMATCH  = 5'd18;
    localparam logic [4:0] STOP_INSERTION = 5'd19;
    localparam logic [4:0] STOP_DELETION  = 5'd20;

    typedef enum logic [2:0] {
        IDLE,
        RD_K,
        RD_L,
        WAIT_L,
        DONE
    } state_t;

    state_t      state;
    logic [1:0]  base_dec;
    logic [1:0]  b_q;
    logic [7:0]  i_q;
    logic [7:0]  z_q;
    logic [7:0]  k_q;
    logic [7:0]  l_q;
    logic [11:0] addr_q;
    logic [4:0]  pos_q;
    logic [7:0]  d_i_q;
    logic [1:0]  read_i_q;
    logic [7:0]  c_q;
    logic [7:0]  occ_k_q;
    logic [7:0]  k_sum;
    logic [7:0]  l_sum;

    // Codes outside the four bases fall back to b=0; upstream never requests a lookup with them.
    always_comb begin
        base_dec = 2'd0;
        case (position_in)
            A_MATCH, A_MISMATCH, A_INSERTION, A_DELETION: base_dec = 2'd0;
            C_MATCH, C_MISMATCH, C_INSERTION, C_DELETION: base_dec = 2'd1;
            G_MATCH, G_MISMATCH, G_INSERTION, G_DELETION: base_dec = 2'd2;
            T_MATCH, T_MISMATCH, T_INSERTION, T_DELETION: base_dec = 2'd3;
            NONE, STOP_MATCH, STOP_MISMATCH, STOP_INSERTION, STOP_DELETION: base_dec = 2'd0;
            default: base_dec = 2'd0;
        endcase
    end

    // 8-bit sums wrap modulo 256, matching the truncated 9-bit result.
    always_comb begin
        k_sum = c_q + occ_k_q + 8'd1;
        l_sum = c_q + occ_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            ce_rom_Occ     <= 1'b0;
            addr_rom_Occ   <= '0;
            out_valid      <= 1'b0;
            i_out          <= '0;
            z_out          <= '0;
            k_out          <= '0;
            l_out          <= '0;
            addr_out       <= '0;
            position_out   <= '0;
            d_i_out        <= '0;
            read_i_out     <= '0;
            k_new          <= '0;
            l_new          <= '0;
            interval_empty <= 1'b0;
            b_q            <= '0;
            i_q            <= '0;
            z_q            <= '0;
            k_q            <= '0;
            l_q            <= '0;
            addr_q         <= '0;
            pos_q          <= '0;
            d_i_q          <= '0;
            read_i_q       <= '0;
            c_q            <= '0;
            occ_k_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        b_q      <= base_dec;
                        i_q      <= i_in;
                        z_q      <= z_in;
                        k_q      <= k_in;
                        l_q      <= l_in;
                        addr_q   <= addr_in;
                        pos_q    <= position_in;
                        d_i_q    <= d_i_in;
                        read_i_q <= read_i_in;
                        c_q      <= C_in;
                        if (need_occ) begin
                            state <= RD_K;
                            // With k=0 there is no Occ(b,-1) to read; the term is forced to 0 later.
                            if (k_in != 8'd0) begin
                                ce_rom_Occ   <= 1'b1;
                                addr_rom_Occ <= {base_dec, k_in - 8'd1};
                            end else begin
                                ce_rom_Occ   <= 1'b0;
                                addr_rom_Occ <= '0;
                            end
                        end else begin
                            state          <= DONE;
                            out_valid      <= 1'b1;
                            i_out          <= i_in;
                            z_out          <= z_in;
                            k_out          <= k_in;
                            l_out          <= l_in;
                            addr_out       <= addr_in;
                            position_out   <= position_in;
                            d_i_out        <= d_i_in;
                            read_i_out     <= read_i_in;
                            k_new          <= k_in;
                            l_new          <= l_in;
                            interval_empty <= (k_in > l_in);
                        end
                    end
                end
                RD_K: begin
                    ce_rom_Occ   <= 1'b1;
                    addr_rom_Occ <= {b_q, l_q};
                    state        <= RD_L;
                end
                RD_L: begin
                    ce_rom_Occ   <= 1'b0;
                    addr_rom_Occ <= '0;
                    occ_k_q      <= (k_q == 8'd0) ? 8'd0 : occ_data;
                    state        <= WAIT_L;
                end
                WAIT_L: begin
                    out_valid      <= 1'b1;
                    i_out          <= i_q;
                    z_out          <= z_q;
                    k_out          <= k_q;
                    l_out          <= l_q;
                    addr_out       <= addr_q;
                    position_out   <= pos_q;
                    d_i_out        <= d_i_q;
                    read_i_out     <= read_i_q;
                    k_new          <= k_sum;
                    l_new          <= l_sum;
                    interval_empty <= (k_sum > l_sum);
                    state          <= DONE;
                end
                DONE: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
